// File: rtl/i2s_tx_fifo_pkg.sv
// Shared types and helpers for the I2S transmitter with input FIFO.
package i2s_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } i2s_state_t;

    localparam logic MODE_I2S = 1'b0;
    localparam logic MODE_LJ  = 1'b1;

    // Width of the frame bit index that counts 0 .. 2*slot_w-1
    function automatic int unsigned bit_cnt_w(input int unsigned slot_w);
        return $clog2(2 * slot_w);
    endfunction

endpackage

// File: rtl/i2s_tx_fifo_if.sv
// Stereo frame stream into the transmitter: valid/ready handshake.
interface i2s_tx_fifo_if #(
    parameter int unsigned DATA_W = 16
) ();
    logic [2*DATA_W-1:0] s_data;
    logic                s_valid;
    logic                s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/i2s_tx_fifo_sync_fifo.sv
// Single-clock FIFO with occupancy count; read data is the head entry (show-ahead).
module sync_fifo
    import i2s_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               wdata,
    output logic [WIDTH-1:0]               rdata,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     level
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                level <= level + 1'b1;
            end else if (pop_ok && !push_ok) begin
                level <= level - 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2s_tx_fifo.sv
// I2S / left-justified stereo transmitter fed from a frame FIFO.
module i2s_tx_fifo
    import i2s_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned SLOT_W     = 32,
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    i2s_tx_fifo_if.slave                         s,
    input  logic                                 enable,
    input  logic                                 mode,
    input  logic                                 mute,
    output logic                                 SCLK,
    output logic                                 WS,
    output logic                                 SD,
    output logic                                 underflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_level
);
    localparam int unsigned FRAME_W = 2 * DATA_W;
    localparam int unsigned BIT_W   = bit_cnt_w(SLOT_W);
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(2 * SLOT_W - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    i2s_state_t         state;
    logic [DIV_W-1:0]   div_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [FRAME_W-1:0] frame;
    logic               mode_r;

    logic               fifo_full;
    logic               fifo_empty;
    logic [FRAME_W-1:0] fifo_rdata;
    logic               push;
    logic               pop;

    logic               falling;
    logic               wrap;
    logic               load;
    logic [BIT_W-1:0]   next_bit;
    logic [FRAME_W-1:0] new_frame;
    logic [FRAME_W-1:0] frame_eff;
    logic               mode_eff;

    assign s.s_ready = !fifo_full;
    assign push      = s.s_valid && !fifo_full;

    sync_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (s.s_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Left-justified stream bit for frame bit index b
    function automatic logic lj_bit(input logic [FRAME_W-1:0] f, input int unsigned b);
        int unsigned       p;
        logic [DATA_W-1:0] chan;
        logic [DATA_W-1:0] sh;
        p    = b % SLOT_W;
        chan = (b >= SLOT_W) ? f[DATA_W-1:0] : f[FRAME_W-1:DATA_W];
        sh   = chan >> (DATA_W - 1 - p);
        return (p < DATA_W) ? sh[0] : 1'b0;
    endfunction

    // Edge detection, frame-load decision and next-bit selection
    always_comb begin
        falling   = (state == RUN) && enable && (div_cnt == DIV_LAST) && SCLK;
        wrap      = falling && (bit_cnt == LAST_BIT);
        load      = ((state == IDLE) && enable) || wrap;
        pop       = load && !fifo_empty;
        next_bit  = wrap ? '0 : bit_cnt + 1'b1;
        new_frame = (!fifo_empty && !mute) ? fifo_rdata : '0;
        frame_eff = wrap ? new_frame : frame;
        mode_eff  = wrap ? mode : mode_r;
    end

    // Control FSM with registered serial outputs.
    // The I2S one-bit delay reuses the held frame: the bit sent after a falling
    // edge is the LJ bit of the index just left, taken before the frame reloads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            frame     <= '0;
            mode_r    <= MODE_I2S;
            SCLK      <= 1'b0;
            WS        <= 1'b0;
            SD        <= 1'b0;
            underflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    SCLK    <= 1'b0;
                    WS      <= 1'b0;
                    if (enable) begin
                        state     <= RUN;
                        frame     <= new_frame;
                        mode_r    <= mode;
                        SD        <= (mode == MODE_LJ) ? lj_bit(new_frame, 0) : 1'b0;
                        underflow <= fifo_empty;
                    end else begin
                        frame     <= '0;
                        SD        <= 1'b0;
                        underflow <= 1'b0;
                    end
                end
                RUN: begin
                    underflow <= 1'b0;
                    if (!enable) begin
                        state   <= IDLE;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        frame   <= '0;
                        SCLK    <= 1'b0;
                        WS      <= 1'b0;
                        SD      <= 1'b0;
                    end else if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        SCLK    <= !SCLK;
                        if (falling) begin
                            bit_cnt <= next_bit;
                            WS      <= (32'(next_bit) >= SLOT_W);
                            SD      <= (mode_eff == MODE_LJ) ? lj_bit(frame_eff, 32'(next_bit))
                                                             : lj_bit(frame, 32'(bit_cnt));
                            if (wrap) begin
                                frame     <= new_frame;
                                mode_r    <= mode;
                                underflow <= fifo_empty;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_tx_fifo.sv
// Scoreboard bench for i2s_tx_fifo: frames queued on push, serial stream
// reassembled on SCLK rising edges and compared against the expected stream.
module tb_i2s_tx_fifo;
    import i2s_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable, en24, mode, mute;
    logic       sclk16, ws16, sd16, uf16;
    logic       sclk24, ws24, sd24, uf24;
    logic [2:0] lvl16, lvl24;

    i2s_tx_fifo_if #(.DATA_W(16)) bus16 ();
    i2s_tx_fifo_if #(.DATA_W(16)) bus24 ();

    i2s_tx_fifo #(.DATA_W(16), .SLOT_W(16), .CLK_DIV(2), .FIFO_DEPTH(4)) dut16 (
        .clk(clk), .rst(rst), .s(bus16), .enable(enable), .mode(mode), .mute(mute),
        .SCLK(sclk16), .WS(ws16), .SD(sd16), .underflow(uf16), .fifo_level(lvl16)
    );

    i2s_tx_fifo #(.DATA_W(16), .SLOT_W(24), .CLK_DIV(2), .FIFO_DEPTH(4)) dut24 (
        .clk(clk), .rst(rst), .s(bus24), .enable(en24), .mode(mode), .mute(mute),
        .SCLK(sclk24), .WS(ws24), .SD(sd24), .underflow(uf24), .fifo_level(lvl24)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] sb16[$];
    logic [31:0] sb24[$];
    logic        prev_bit[2];
    int          last_period;

    // Underflow pulse monitor on the 16-bit-slot instance
    int   uf_pulses = 0;
    int   uf_run    = 0;
    int   uf_maxw   = 0;
    logic uf16_d    = 1'b0;
    always @(negedge clk) begin
        uf16_d <= uf16;
        uf_run <= uf16 ? uf_run + 1 : 0;
        if (uf16 && !uf16_d) uf_pulses <= uf_pulses + 1;
        if (uf16 && (uf_run + 1 > uf_maxw)) uf_maxw <= uf_run + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic lj(input logic [31:0] f, input int sw, input int b);
        int          p;
        logic [15:0] ch;
        logic [15:0] sh;
        p  = b % sw;
        ch = (b < sw) ? f[31:16] : f[15:0];
        sh = ch >> (15 - p);
        return (p < 16) ? sh[0] : 1'b0;
    endfunction

    task automatic push(input bit sel, input logic [31:0] d);
        logic acc;
        @(negedge clk);
        if (sel) begin
            bus24.s_data = d; bus24.s_valid = 1'b1; acc = bus24.s_ready;
        end else begin
            bus16.s_data = d; bus16.s_valid = 1'b1; acc = bus16.s_ready;
        end
        @(negedge clk);
        bus16.s_valid = 1'b0;
        bus24.s_valid = 1'b0;
        if (acc) begin
            if (sel) sb24.push_back(mute ? 32'h0 : d);
            else     sb16.push_back(mute ? 32'h0 : d);
        end
    endtask

    // Capture n bits (WS, SD) on consecutive SCLK rising edges, bounded in time
    task automatic collect(input bit sel, input int n, output logic [63:0] sdb,
                           output logic [63:0] wsb, output int period, output int got);
        int   budget;
        int   first;
        logic last;
        logic cur;
        sdb = '0; wsb = '0; period = 0; got = 0; budget = 0; first = 0;
        last = sel ? sclk24 : sclk16;
        while (got < n && budget < 1000) begin
            @(negedge clk);
            budget++;
            cur = sel ? sclk24 : sclk16;
            if (cur && !last) begin
                sdb = {sdb[62:0], (sel ? sd24 : sd16)};
                wsb = {wsb[62:0], (sel ? ws24 : ws16)};
                if (got == 0) first = budget;
                if (got == 1) period = budget - first;
                got++;
            end
            last = cur;
        end
    endtask

    task automatic expect_frame(input bit sel, input bit md, input string tag,
                                output logic [63:0] sdb);
        logic [31:0] f;
        logic [63:0] wsb, esd, ews;
        int          sw, n, per, got;
        sw = sel ? 24 : 16;
        n  = 2 * sw;
        f  = 32'h0;
        if (sel) begin
            if (sb24.size() > 0) f = sb24.pop_front();
        end else begin
            if (sb16.size() > 0) f = sb16.pop_front();
        end
        collect(sel, n, sdb, wsb, per, got);
        esd = '0; ews = '0;
        for (int b = 0; b < n; b++) begin
            if (md) esd[n-1-b] = lj(f, sw, b);
            else    esd[n-1-b] = (b == 0) ? prev_bit[sel] : lj(f, sw, b - 1);
            ews[n-1-b] = (b >= sw);
        end
        prev_bit[sel] = lj(f, sw, n - 1);
        last_period   = per;
        check({tag, " samples"}, 64'(got), 64'(n));
        check({tag, " sd"}, sdb, esd);
        check({tag, " ws"}, wsb, ews);
    endtask

    initial begin
        logic [63:0] sdb;
        int          uf_ref;
        int          rises;
        logic        last, cur;

        rst = 1'b0; enable = 1'b0; en24 = 1'b0; mode = MODE_LJ; mute = 1'b0;
        bus16.s_data = '0; bus16.s_valid = 1'b0;
        bus24.s_data = '0; bus24.s_valid = 1'b0;
        prev_bit[0] = 1'b0; prev_bit[1] = 1'b0;

        repeat (3) @(negedge clk);
        check("rst sclk", 64'(sclk16), 64'd0);
        check("rst ws", 64'(ws16), 64'd0);
        check("rst sd", 64'(sd16), 64'd0);
        check("rst underflow", 64'(uf16), 64'd0);
        check("rst level", 64'(lvl16), 64'd0);
        check("rst ready", 64'(bus16.s_ready), 64'd1);
        rst = 1'b1;
        @(negedge clk);

        // Left-justified basic frame, then an underflow frame
        mode = MODE_LJ;
        push(0, 32'h00C2_AA59);
        check("lj level", 64'(lvl16), 64'd1);
        uf_ref = uf_pulses;
        enable = 1'b1;
        expect_frame(0, MODE_LJ, "lj1", sdb);
        check("lj1 const", sdb, 64'h00C2_AA59);
        check("sclk period", 64'(last_period), 64'd4);
        check("no uf before empty", 64'(uf_pulses - uf_ref), 64'd0);
        expect_frame(0, MODE_LJ, "uf frame", sdb);
        enable = 1'b0;
        check("uf pulses", 64'(uf_pulses - uf_ref), 64'd1);
        check("uf width", 64'(uf_maxw), 64'd1);
        repeat (2) @(negedge clk);
        prev_bit[0] = 1'b0;

        // Muted frame is consumed but sent as zeros
        mute = 1'b1;
        push(0, 32'h1234_5678);
        uf_ref = uf_pulses;
        enable = 1'b1;
        expect_frame(0, MODE_LJ, "mute", sdb);
        enable = 1'b0;
        check("mute level", 64'(lvl16), 64'd0);
        check("mute no uf", 64'(uf_pulses - uf_ref), 64'd0);
        mute = 1'b0;
        repeat (2) @(negedge clk);
        prev_bit[0] = 1'b0;

        // Philips I2S: stream delayed by one SCLK
        mode = MODE_I2S;
        push(0, 32'h00C2_AA59);
        push(0, 32'h8001_7FFE);
        enable = 1'b1;
        expect_frame(0, MODE_I2S, "i2s1", sdb);
        check("i2s left lsb after ws edge", 64'(sdb[15]), 64'd0);
        check("i2s right msb b17", 64'(sdb[14]), 64'd1);
        expect_frame(0, MODE_I2S, "i2s2", sdb);
        enable = 1'b0;
        mode = MODE_LJ;
        repeat (2) @(negedge clk);
        prev_bit[0] = 1'b0;

        // Full FIFO: fifth frame refused, four emerge in order
        push(0, 32'h1111_AAAA);
        push(0, 32'h2222_BBBB);
        push(0, 32'h3333_CCCC);
        push(0, 32'h4444_DDDD);
        push(0, 32'h5555_EEEE);
        check("full level", 64'(lvl16), 64'd4);
        check("full ready", 64'(bus16.s_ready), 64'd0);
        uf_ref = uf_pulses;
        enable = 1'b1;
        for (int i = 0; i < 4; i++) expect_frame(0, MODE_LJ, "full order", sdb);
        enable = 1'b0;
        check("full no uf", 64'(uf_pulses - uf_ref), 64'd0);
        repeat (2) @(negedge clk);
        prev_bit[0] = 1'b0;

        // Slot padding on the 24-SCLK-slot instance
        push(1, 32'hFFFF_FFFF);
        en24 = 1'b1;
        expect_frame(1, MODE_LJ, "pad", sdb);
        check("pad const", sdb, 64'hFFFF00_FFFF00);
        en24 = 1'b0;
        repeat (2) @(negedge clk);

        // Abort at b=7: frame dropped, not re-queued
        push(0, 32'hDEAD_BEEF);
        push(0, 32'h0F0F_A5A5);
        enable = 1'b1;
        rises = 0;
        last = sclk16;
        for (int k = 0; k < 200 && rises < 7; k++) begin
            @(negedge clk);
            cur = sclk16;
            if (cur && !last) rises++;
            last = cur;
        end
        check("abort rises", 64'(rises), 64'd7);
        repeat (2) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("abort outputs idle", {61'd0, sclk16, ws16, sd16}, 64'd0);
        check("abort level kept", 64'(lvl16), 64'd1);
        void'(sb16.pop_front());
        prev_bit[0] = 1'b0;
        enable = 1'b1;
        expect_frame(0, MODE_LJ, "after abort", sdb);
        enable = 1'b0;
        repeat (2) @(negedge clk);

        // Asynchronous reset mid-frame
        push(0, 32'hCAFE_F00D);
        push(0, 32'h5A5A_0001);
        enable = 1'b1;
        repeat (10) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("async rst outputs", {61'd0, sclk16, ws16, sd16}, 64'd0);
        check("async rst level", 64'(lvl16), 64'd0);
        @(negedge clk);
        enable = 1'b0;
        rst = 1'b1;
        sb16.delete();
        @(negedge clk);
        check("post rst level", 64'(lvl16), 64'd0);
        check("post rst ready", 64'(bus16.s_ready), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/i2s_tx_fifo.md
Name: i2s_tx_fifo

Overview:
Parametrised I2S/left-justified stereo transmitter with an input sample FIFO, the successor to the fixed-width I2S transmitter. It accepts stereo frames over a valid/ready stream, generates SCLK/WS/SD from the system clock with a programmable divider, and supports slot widths wider than the sample width. It sits between the decoder output buffer and the DAC pins.

Parameters:
DATA_W, 16, sample bits per channel; must be >= 1.
SLOT_W, 32, SCLK periods per channel slot; must be >= DATA_W.
CLK_DIV, 4, clk cycles per SCLK half-period; must be >= 1.
FIFO_DEPTH, 4, stereo frames buffered; power of 2, >= 2.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
s_data  in  2*DATA_W  stereo frame: {left[DATA_W-1:0], right[DATA_W-1:0]}, left in the upper half
s_valid  in  1  s_data valid
s_ready  out  1  FIFO can accept a frame (= not full)
enable  in  1  run the serial interface
mode  in  1  0 = Philips I2S (SD one SCLK behind WS), 1 = left-justified
mute  in  1  transmit zeros; frames are still consumed
SCLK  out  1  serial bit clock
WS  out  1  word select: 0 = left slot, 1 = right slot
SD  out  1  serial data, MSB first
underflow  out  1  one-clk pulse when a frame boundary finds the FIFO empty
fifo_level  out  $clog2(FIFO_DEPTH+1)  frames currently stored

Behaviour:
- Reset (rst=0, async): SCLK=0, WS=0, SD=0, underflow=0, FIFO empty, fifo_level=0, s_ready=1, FSM=IDLE, all counters 0.
- FIFO: push when s_valid && s_ready. s_ready = !full, so a push is refused when full even if a pop occurs in the same cycle. Simultaneous push and pop when not full or empty leaves the level unchanged. Read/write pointers wrap modulo FIFO_DEPTH. Writes are accepted in IDLE and RUN.
- FSM IDLE: SCLK=0, WS=0, SD=0, divider and bit counter held at 0.
  - First clk edge with enable=1: go to RUN and do a frame load. SCLK stays 0.
  - WS=0, and SD is driven immediately: in mode 1, SD = left MSB; in mode 0, SD = 0.
- FSM RUN, divider: counts 0..CLK_DIV-1. SCLK toggles each time it wraps. One SCLK period is 2*CLK_DIV clk cycles.
- FSM RUN, falling edge: on the clk edge where SCLK goes 1->0, the frame bit index b (0..2*SLOT_W-1) increments modulo 2*SLOT_W. WS and SD update on that same edge, so receivers sample on SCLK rising.
- WS = (b >= SLOT_W) in both modes.
- Left-justified serial stream LJ(b): slot position p = b mod SLOT_W. LJ = channel bit (DATA_W-1-p) for p < DATA_W, else 0.
- SD in mode 1 = LJ(b). SD in mode 0 = LJ(b-1) via one extra SCLK-domain delay stage. As a result, the MSB appears one SCLK after the WS edge, and the last LSB spills into the next slot.
- Frame load: happens on entry to RUN and on every falling edge where b wraps 2*SLOT_W-1 -> 0.
  - FIFO non-empty: pop into a 2*DATA_W shift/hold register, or zeros if mute=1.
  - FIFO empty: load zeros and pulse underflow for exactly one clk cycle.
- mode and mute are sampled only at a frame load. A change mid-frame takes effect at the next frame.
- enable=0 in RUN: return to IDLE on the next edge. The current frame is discarded and not re-queued. Outputs go to their IDLE values. The FIFO contents are kept.
- No combinational path from s_valid to any serial output.

Decomposition:
- Package i2s_pkg holds:
  - typedef enum {IDLE, RUN} i2s_state_t;
  - localparam MODE_I2S=1'b0, MODE_LJ=1'b1;
  - a function computing the bit-counter width $clog2(2*SLOT_W).
- One sub-module, sync_fifo (params WIDTH, DEPTH; ports clk, rst, push, pop, wdata, rdata, full, empty, level), with the same async active-low reset.

Test Plan:
- Setup for all scenarios: DATA_W=16, SLOT_W=16, CLK_DIV=2.
- LJ basic: push 32'h00C2_AA59, mode=1, enable=1.
  - WS=0 for 16 SCLKs with SD=0000_0000_1100_0010, then WS=1 with SD=1010_1010_0101_1001.
  - SCLK period = 4 clk.
- I2S mode: same frame with mode=0.
  - SD is the LJ sequence delayed one SCLK. First SD bit after the WS 0->1 edge is 0 (the left LSB).
  - Right MSB (1) appears at b=17.
- Padding: SLOT_W=24, push 32'hFFFF_FFFF, mode=1.
  - Each slot is 16 ones followed by 8 zeros. WS toggles every 24 SCLKs.
- Underflow/mute: push one frame, then none. Second frame load sends all zeros with a single-cycle underflow pulse. Then push 32'h1234_5678 with mute=1: frame is popped, SD stays 0, fifo_level returns to 0.
- Full FIFO: hold enable=0 and push 5 frames. fifo_level=4, s_ready=0, 5th frame dropped. Enable: frames emerge in order.
- Reset/abort: drop enable at b=7, then drop rst mid-frame. Outputs go to 0 immediately on rst (async). After release: fifo_level=0, s_ready=1.
